// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU (fixed priority) and DMA share one synchronous
// single-port memory, with a starvation guard for the DMA and read-return steering.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    owner_e            owner_q, owner_d;
    logic              tag_valid_q, tag_valid_d;
    owner_e            tag_owner_q, tag_owner_d;

    logic starve_hit;
    logic any_gnt;

    // Winner selection: CPU first, unless the DMA has waited STARVE_MAX cycles.
    assign starve_hit = (starve_q == STARVE_LIM);
    assign dma_gnt    = dma_req & (~cpu_req | starve_hit);
    assign cpu_gnt    = cpu_req & ~dma_gnt;
    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign any_gnt    = cpu_gnt | dma_gnt;

    always_comb begin
        starve_d = starve_q;
        if (!dma_req || dma_gnt) begin
            starve_d = '0;
        end else if (!starve_hit) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Issue stage: capture the winner's access; address/data hold when idle.
    always_comb begin
        mem_en_d    = any_gnt;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        if (dma_gnt) begin
            mem_we_d    = dma_we;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
            owner_d     = OWN_DMA;
        end else if (cpu_gnt) begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            owner_d     = OWN_CPU;
        end
    end

    // Return tag follows the read strobe by one cycle, matching memory latency.
    always_comb begin
        tag_valid_d = mem_en_q & ~mem_we_q;
        tag_owner_d = owner_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= OWN_CPU;
            tag_valid_q <= 1'b0;
            tag_owner_q <= OWN_CPU;
        end else begin
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
            tag_valid_q <= tag_valid_d;
            tag_owner_q <= tag_owner_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    assign cpu_rvalid = tag_valid_q & (tag_owner_q == OWN_CPU);
    assign dma_rvalid = tag_valid_q & (tag_owner_q == OWN_DMA);
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed table-driven bench for dmem_port_arbiter with a small memory model
// behind the port so read data can be checked end to end.
module tb_dmem_port_arbiter;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam logic [31:0] CWD = 32'hC0C0_0000;
    localparam logic [31:0] DBF = 32'hDEAD_BEEF;
    localparam logic [31:0] D20 = 32'h2222_0020;
    localparam int NV = 37;
    localparam int NH = 13;

    logic        clk, rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem_model [256];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        cr; logic cw; logic [31:0] ca;
        logic        dr; logic dw; logic [31:0] da; logic [31:0] dwd;
        logic        ecg; logic edg; logic est;
        logic        een; logic ewe;
        logic        ecv; logic edv;
        logic        chk; logic [31:0] eaddr; logic [31:0] ewd; logic [31:0] erd;
    } vec_t;

    vec_t vecs [NV];
    vec_t hvec [NH];

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr[9:2]];
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input string tag, input int idx, input vec_t v);
        logic [6:0] act, exp;
        @(negedge clk);
        cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = CWD;
        dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dwd;
        #1;
        act = {cpu_gnt, dma_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, dma_rvalid};
        exp = {v.ecg, v.edg, v.est, v.een, v.ewe, v.ecv, v.edv};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] {cgnt,dgnt,stall,en,we,crv,drv}: got %b want %b", tag, idx, act, exp);
        end
        if (v.chk)          check32($sformatf("%s[%0d] mem_addr", tag, idx), mem_addr, v.eaddr);
        if (v.chk && v.ewe) check32($sformatf("%s[%0d] mem_wdata", tag, idx), mem_wdata, v.ewd);
        if (v.ecv)          check32($sformatf("%s[%0d] cpu_rdata", tag, idx), cpu_rdata, v.erd);
        if (v.edv)          check32($sformatf("%s[%0d] dma_rdata", tag, idx), dma_rdata, v.erd);
    endtask

    initial begin
        vec_t idle;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        mem_model[16] = DBF;            // 0x40
        mem_model[4]  = 32'h1111_0010;  // 0x10
        mem_model[8]  = D20;            // 0x20
        mem_rdata = 32'h0;

        idle = '{N,N,0, N,N,0,0, N,N,N, N,N, N,N, Y,32'h0,32'h0,32'h0};

        vecs[0]  = '{Y,N,32'h40, N,N,0,0,          Y,N,N, N,N, N,N, N,0,0,0};
        vecs[1]  = '{N,N,0, N,N,0,0,               N,N,N, Y,N, N,N, Y,32'h40,0,0};
        vecs[2]  = '{N,N,0, N,N,0,0,               N,N,N, N,N, Y,N, Y,32'h40,0,DBF};
        vecs[3]  = '{Y,N,32'h10, N,N,0,0,          Y,N,N, N,N, N,N, N,0,0,0};
        vecs[4]  = '{N,N,0, Y,N,32'h20,0,          N,Y,N, Y,N, N,N, Y,32'h10,0,0};
        vecs[5]  = '{N,N,0, N,N,0,0,               N,N,N, Y,N, Y,N, Y,32'h20,0,32'h1111_0010};
        vecs[6]  = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,Y, Y,32'h20,0,D20};
        vecs[7]  = '{N,N,0, Y,Y,32'h8,32'h1234,    N,Y,N, N,N, N,N, N,0,0,0};
        vecs[8]  = '{N,N,0, N,N,0,0,               N,N,N, Y,Y, N,N, Y,32'h8,32'h1234,0};
        vecs[9]  = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,N, Y,32'h8,0,0};
        vecs[10] = '{N,N,0, Y,N,32'h8,0,           N,Y,N, N,N, N,N, N,0,0,0};
        vecs[11] = '{N,N,0, N,N,0,0,               N,N,N, Y,N, N,N, Y,32'h8,0,0};
        vecs[12] = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,Y, N,0,0,32'h1234};
        // Both requesting continuously: four CPU grants, then one forced DMA grant.
        vecs[13] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, N,N, N,N, N,0,0,0};
        vecs[14] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, N,N, Y,32'h40,0,0};
        vecs[15] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        vecs[16] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        vecs[17] = '{Y,N,32'h40, Y,N,32'h20,0,     N,Y,Y, Y,N, Y,N, N,0,0,DBF};
        vecs[18] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, Y,32'h20,0,DBF};
        vecs[19] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, N,Y, Y,32'h40,0,D20};
        vecs[20] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        vecs[21] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        vecs[22] = '{Y,N,32'h40, Y,N,32'h20,0,     N,Y,Y, Y,N, Y,N, N,0,0,DBF};
        vecs[23] = '{N,N,0, N,N,0,0,               N,N,N, Y,N, Y,N, Y,32'h20,0,DBF};
        vecs[24] = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,Y, N,0,0,D20};
        vecs[25] = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,N, N,0,0,0};
        // A cycle with dma_req low restarts the starvation count.
        vecs[26] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, N,N, N,N, N,0,0,0};
        vecs[27] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, N,N, N,0,0,0};
        vecs[28] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        vecs[29] = '{Y,N,32'h40, N,N,0,0,          Y,N,N, Y,N, Y,N, N,0,0,DBF};
        vecs[30] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        vecs[31] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        vecs[32] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        vecs[33] = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        vecs[34] = '{Y,N,32'h40, Y,N,32'h20,0,     N,Y,Y, Y,N, Y,N, N,0,0,DBF};
        vecs[35] = '{N,N,0, N,N,0,0,               N,N,N, Y,N, Y,N, Y,32'h20,0,DBF};
        vecs[36] = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,Y, N,0,0,D20};

        // Post-reset sequence: starvation count must restart from zero.
        hvec[0]  = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,N, Y,32'h0,0,0};
        hvec[1]  = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,N, Y,32'h0,0,0};
        hvec[2]  = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,N, Y,32'h0,0,0};
        hvec[3]  = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, N,N, N,N, N,0,0,0};
        hvec[4]  = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, N,N, Y,32'h40,0,0};
        hvec[5]  = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        hvec[6]  = '{Y,N,32'h40, Y,N,32'h20,0,     Y,N,N, Y,N, Y,N, N,0,0,DBF};
        hvec[7]  = '{Y,N,32'h40, Y,N,32'h20,0,     N,Y,Y, Y,N, Y,N, N,0,0,DBF};
        hvec[8]  = '{N,N,0, N,N,0,0,               N,N,N, Y,N, Y,N, Y,32'h20,0,DBF};
        hvec[9]  = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,Y, N,0,0,D20};
        hvec[10] = '{N,N,0, N,N,0,0,               N,N,N, N,N, N,N, N,0,0,0};
        hvec[11] = '{Y,N,32'h40, N,N,0,0,          Y,N,N, N,N, N,N, N,0,0,0};
        hvec[12] = '{N,N,0, N,N,0,0,               N,N,N, Y,N, N,N, Y,32'h40,0,0};

        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = CWD;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

        // Held in reset for three cycles with no requests.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check32($sformatf("rst[%0d] {en,we,cgnt,dgnt,crv,drv}", i),
                    32'({mem_en, mem_we, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}), 32'h0);
        end
        check32("rst mem_addr", mem_addr, 32'h0);
        check32("rst mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) apply("idle", i, idle);
        for (int i = 0; i < NV; i++) apply("vec", i, vecs[i]);

        // Build up starvation and issue a CPU read, then reset mid-flight.
        apply("pre", 0, '{Y,N,32'h40, Y,N,32'h20,0, Y,N,N, N,N, N,N, N,0,0,0});
        apply("pre", 1, '{Y,N,32'h40, Y,N,32'h20,0, Y,N,N, Y,N, N,N, Y,32'h40,0,0});
        apply("pre", 2, '{Y,N,32'h40, Y,N,32'h20,0, Y,N,N, Y,N, Y,N, N,0,0,DBF});
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check32("midrst {en,we,crv,drv}", 32'({mem_en, mem_we, cpu_rvalid, dma_rvalid}), 32'h0);
        check32("midrst mem_addr", mem_addr, 32'h0);
        check32("midrst {cgnt,dgnt,stall}", 32'({cpu_gnt, dma_gnt, cpu_stall}), 32'b100);
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NH; i++) apply("post", i, hvec[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter sharing the single-port data memory between the pipeline MEM stage (CPU) and the program/data loader (DMA). It grants one access per cycle, drives registered memory control signals, and steers the synchronous-read return data back to the requester that issued it. The CPU has fixed priority. A starvation counter guarantees the DMA a slot within a bounded number of cycles.

## Interface
- ADDR_W, 32, memory address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied DMA request cycles before the DMA is forced to win (legal range 1..15)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state
- cpu_req / dma_req  in  1  access request; held until granted
- cpu_we / dma_we  in  1  1 = write, 0 = read
- cpu_addr / dma_addr  in  ADDR_W  access address
- cpu_wdata / dma_wdata  in  DATA_W  write data
- cpu_gnt / dma_gnt  out  1  combinational; request accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt, to the hazard unit
- cpu_rvalid / dma_rvalid  out  1  read data valid this cycle
- cpu_rdata / dma_rdata  out  DATA_W  read data, always driven with mem_rdata
- mem_en, mem_we  out  1  registered memory strobe and write enable
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe

## Operation
- Arbitration is evaluated every cycle. Nothing is ever in flight that blocks a new grant, so throughput is 1 access/cycle.
- Winner selection:
  - Only one requester requesting: that requester wins.
  - Both requesting: CPU wins unless starve_cnt == STARVE_MAX, in which case DMA wins.
  - Exactly one of cpu_gnt / dma_gnt may be high in any cycle. Neither is high when there is no request.
- Starvation counter starve_cnt (4 bits):
  - Cleared on a DMA grant, or in any cycle dma_req = 0.
  - Incremented when dma_req = 1 and dma_gnt = 0.
  - Saturates at STARVE_MAX.
- Issue stage, registered on a grant:
  - mem_en = 1; mem_we, mem_addr and mem_wdata are taken from the winner.
  - With no grant: mem_en = 0 and mem_we = 0; addr/wdata hold their previous values.
- Owner tracking for reads:
  - A one-entry return tag {valid, owner} is set when a read issues (mem_en & ~mem_we).
  - The tag's requester sees rvalid = 1 exactly one cycle after the strobe.
  - Writes produce no rvalid.
- The requester must not change its request fields in the cycle gnt is low. It may drop req or present a new request in the cycle after gnt.

## Timing
- Reset values: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, both rvalid = 0, starve_cnt = 0, return tag invalid. Gnt and stall follow their inputs combinationally during reset.
- Read latency: gnt in cycle N, mem_en in N+1, rvalid/rdata at the requester in N+2.
- Write latency: gnt in N, memory write strobe in N+1.
- Back-to-back reads from alternating owners return in issue order. Each rvalid goes to the correct owner with no bubble.
- Simultaneous requests with starve_cnt reaching STARVE_MAX on the same edge: the DMA wins in the following cycle, not the current one.
- Reset asserted mid-operation: all in-flight strobes and pending rvalids are dropped immediately (asynchronously). No rvalid appears after reset release until a new read issues.
- Reset release: the first grant can occur in the first cycle after rst rises.

## Test plan
- Reset then idle: rst low for 3 cycles, no requests -> mem_en = 0, rvalid = 0, all grants 0 for 10 cycles.
- CPU read alone: cpu_req = 1, we = 0, addr = 0x40, memory returns 0xDEADBEEF -> cpu_gnt in N, mem_en with mem_addr = 0x40 in N+1, cpu_rvalid = 1 with rdata 0xDEADBEEF in N+2; dma_rvalid stays 0.
- Starvation, STARVE_MAX = 4: cpu_req and dma_req held high continuously -> pattern of 4 cpu_gnt then 1 dma_gnt, repeating; cpu_stall = 1 only in DMA-grant cycles.
- Interleaved reads, tag steering: CPU read 0x10 in N, DMA read 0x20 in N+1 -> cpu_rvalid in N+2, dma_rvalid in N+3; each gets its own data; never both high in one cycle.
- Write has no return: DMA write 0x8 = 0x1234 -> mem_we = 1, mem_wdata = 0x1234 in N+1; no rvalid on either port in N+2.
- Reset mid-read: CPU read granted in N, rst low in N+1 -> mem_en = 0 and cpu_rvalid = 0 immediately; no rvalid after release; starve_cnt restarts from 0.
